rrb_grant_sequencer: RTL
========================

Name: rrb_grant_sequencer

Overview:
Round-robin grant sequencer that shares one datapath resource among N requesters. It holds a one-hot priority pointer and runs a 4-state FSM (IDLE/ARB/GRANT/RELEASE). It issues a registered one-hot grant with a bounded burst length and rotates priority past the last winner on every release. It is the top-level controller for the RRB priority/next-grant datapath.

Parameters:
N, 4, number of requesters (N >= 2).
BURST_MAX, 8, maximum consecutive GRANT cycles per winner before forced release (BURST_MAX >= 1).
IDW, $clog2(N), width of gnt_id (derived, not overridden).
BCW, $clog2(BURST_MAX), width of burst counter (derived).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  allows new arbitration; does not abort a grant in progress.
req  in  N  per-requester request level.
done  in  N  per-requester release pulse; only the bit for the current winner is honoured.
gnt  out  N  registered one-hot grant; all zero outside GRANT.
gnt_valid  out  1  high exactly while in GRANT.
gnt_id  out  IDW  index of current or last winner.
prior  out  N  one-hot priority pointer; highest-priority requester for the next arbitration.
idle  out  1  high in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, prior=1 (bit 0), burst count=0, idle=1. Outputs clear immediately, independent of clk.
- IDLE: gnt=0. If enable && |req, go to ARB; else stay.
- ARB, one cycle:
  - Winner = first set req bit searching upward from the prior index, wrapping N-1 -> 0.
  - If |req=0, return to IDLE and leave prior unchanged.
  - Otherwise register gnt=one-hot(winner), gnt_id=winner, gnt_valid=1, clear burst count, go to GRANT.
- GRANT:
  - gnt is held stable; burst count increments each cycle.
  - Exit to RELEASE on the first of: done[gnt_id]=1; req[gnt_id]=0; burst count == BURST_MAX-1.
  - A winner holding req without done therefore gets exactly BURST_MAX grant cycles.
- RELEASE, one cycle:
  - gnt=0, gnt_valid=0.
  - prior <= one-hot((gnt_id+1) mod N); gnt_id is retained.
  - Next state is ARB if enable && |req, else IDLE.
- Latency: req rising in IDLE at edge t gives ARB at t+1 and gnt at t+2. Back-to-back winners have a 2-cycle gap (RELEASE + ARB).
- enable low:
  - In GRANT it has no effect; the current grant completes normally.
  - In RELEASE it sends the FSM to IDLE.
  - In ARB a winner is still granted, because the ARB decision was already committed by enable in the prior state.
- done bits for non-winning requesters are ignored. done and burst limit in the same cycle produce a single release.
- Only gnt_id's request is checked in GRANT. Other requests can change freely without effect.
- prior changes only in RELEASE or on reset, and is always one-hot.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package rrb_pkg:
  - state enum {IDLE, ARB, GRANT, RELEASE} (2-bit encoding);
  - defaults for N and BURST_MAX;
  - function for one-hot index encode/decode.
- Sub-module rrb_rr_pick: purely combinational rotating priority picker.
  - Inputs req[N] and prior[N].
  - Outputs winner one-hot, winner index and any_req.
  - Instantiated once in the FSM module.

Test Plan:
1. Reset: drive reset=0 mid-simulation with clk stopped -> gnt=0, gnt_valid=0, prior=4'b0001, idle=1 immediately.
2. Single requester: req=4'b0100 at edge 0, done[2] pulse on 3rd grant cycle -> gnt=4'b0100 from edge 2 to 4; gnt=0 at edge 5 (RELEASE); prior=4'b1000; then IDLE once req drops.
3. Full contention: req=4'b1111 held, done=0 -> winners 0,1,2,3,0 in order, each granted exactly 8 cycles, 2-cycle gap between grants, prior 0010->0100->1000->0001.
4. Skip and wrap: prior=4'b0100, req=4'b1011 -> gnt=4'b1000; after release prior=4'b0001 -> gnt=4'b0001.
5. Mid-grant events:
   - reset=0 during GRANT -> gnt clears asynchronously, prior=0001.
   - Separately, enable=0 during GRANT -> burst completes, then IDLE with gnt=0 despite req=4'b1111.
6. Early drop and stray done:
   - req[1] deasserted on 2nd grant cycle -> RELEASE next edge.
   - done[3] asserted while gnt=4'b0010 -> no effect on grant length.

Source files
------------

// File: rtl/rrb_pkg.sv
// Shared types and helpers for the round-robin grant sequencer.
package rrb_pkg;

  // Default sizing for the sequencer.
  localparam int N_DEF         = 4;
  localparam int BURST_MAX_DEF = 8;

  // Sequencer FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // One-hot encode an index into a 32-bit vector; callers truncate to N.
  function automatic logic [31:0] onehot_encode(input int unsigned idx);
    logic [31:0] v;
    v = 32'd0;
    v[idx[4:0]] = 1'b1;
    return v;
  endfunction

  // Decode a one-hot vector to its index; the highest set bit wins if several are set.
  function automatic int unsigned onehot_decode(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rrb_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or above
// the priority pointer wins, wrapping from N-1 back to 0.
module rrb_rr_pick
  import rrb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   prior,
  output logic [N-1:0]   winner,
  output logic [IDW-1:0] winner_idx,
  output logic           any_req
);

  logic [IDW-1:0] base;
  logic           found;
  int             idx;

  assign any_req = |req;

  // Scan upward from the pointer index and keep the first requester seen.
  always_comb begin
    base       = IDW'(onehot_decode(32'(prior)));
    winner_idx = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        winner_idx = IDW'(idx);
      end
    end
  end

  // One-hot form of the winner; all zero when nobody requests.
  always_comb begin
    winner = '0;
    if (any_req) winner = N'(onehot_encode(int'(winner_idx)));
  end

endmodule

// File: rtl/rrb_grant_sequencer.sv
// Round-robin grant sequencer: IDLE -> ARB -> GRANT -> RELEASE, with a
// bounded burst per winner and the priority pointer rotated past the winner
// on every release. Every output is a flop; nothing passes straight through.
//
// Handshake: gnt/gnt_valid are a grant offer, not a valid/ready pair. While
// gnt_valid is high the winner owns the resource; it gives it back either by
// pulsing done[gnt_id] or by dropping req[gnt_id], and the sequencer forces a
// release after BURST_MAX cycles regardless.
module rrb_grant_sequencer
  import rrb_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  localparam int IDW      = $clog2(N),
  localparam int BCW      = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   prior,
  output logic           idle,
  output logic [1:0]     state_dbg
);

  state_t         state_q, state_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [N-1:0]   gnt_d;
  logic           gnt_valid_d;
  logic [IDW-1:0] gnt_id_d;
  logic [N-1:0]   prior_d;
  logic           idle_d;

  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           any_req;
  logic           release_now;
  logic [N-1:0]   prior_after;

  rrb_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req        (req),
    .prior      (prior),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_req    (any_req)
  );

  // Only the winner's own done/req bits matter; the burst limit forces an exit.
  assign release_now = done[gnt_id] || !req[gnt_id] ||
                       (burst_q == BCW'(BURST_MAX - 1));

  // Priority after a release points just past the winner, wrapping to 0.
  always_comb begin
    prior_after = N'(onehot_encode((int'(gnt_id) == N - 1) ? 0 : int'(gnt_id) + 1));
  end

  assign state_dbg = state_q;

  // Next-state and next-output decode; every register holds unless a state says otherwise.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    gnt_id_d    = gnt_id;
    prior_d     = prior;
    unique case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        if (enable && any_req) state_d = ARB;
      end
      ARB: begin
        // enable already qualified entry here, so a winner is granted regardless of it now.
        if (!any_req) begin
          state_d = IDLE;
        end else begin
          gnt_d       = pick_onehot;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
          burst_d     = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        burst_d = burst_q + 1'b1;
        if (release_now) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          prior_d     = prior_after;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        state_d = (enable && any_req) ? ARB : IDLE;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
    idle_d = (state_d == IDLE);
  end

  // State and registered outputs; reset clears them without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      prior     <= N'(1);
      idle      <= 1'b1;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      gnt_id    <= gnt_id_d;
      prior     <= prior_d;
      idle      <= idle_d;
    end
  end

endmodule
